// File: rtl/efi_cfg_pkg.sv
// efi_cfg_pkg: register map, default reset image and commit states
// for the EFI configuration bank.
package efi_cfg_pkg;

  localparam int REG_MODE      = 0;
  localparam int REG_TOOTH_CNT = 1;
  localparam int REG_TOOTH_RES = 2;
  localparam int REG_MISSING   = 3;
  localparam int REG_TRIG_OFS  = 4;
  localparam int REG_IGN_DWELL = 5;
  localparam int REG_IGN_A_ADV = 6;
  localparam int REG_IGN_B_ADV = 7;
  localparam int REG_IGN_MAX   = 8;
  localparam int REG_INJ_MODE  = 9;
  localparam int REG_INJ_A_ANG = 10;
  localparam int REG_INJ_B_ANG = 11;
  localparam int REG_INJ_A_PW  = 12;
  localparam int REG_INJ_B_PW  = 13;
  localparam int REG_STATUS    = 14;
  localparam int REG_PERIOD    = 15;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_DATA_W   = 16;

  // Slot 0 sits in the least significant 16 bits.
  localparam logic [255:0] DEF_RESET_VALS = {
    16'd0,    16'd0,    16'd0,    16'd2000,
    16'd342,  16'd342,  16'd0,    16'd5120,
    16'd2560, 16'd0,    16'd7680, 16'd0,
    16'd2,    16'd128,  16'd60,   16'h0037
  };

  localparam logic [15:0] DEF_RO_MASK = 16'hC000;

  typedef enum logic [1:0] {
    CM_IDLE,
    CM_ARMED,
    CM_APPLY
  } commit_st_e;

endpackage

// File: rtl/efi_cfg_bank_if.sv
// efi_cfg_bank_if: write (valid/ready/err) and read (en/data/valid)
// bus of the config bank; master = SPI side, slave = bank.
interface efi_cfg_bank_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_en, rd_addr, rd_bank,
    input  wr_ready, wr_err,
    input  rd_data, rd_data_valid
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_en, rd_addr, rd_bank,
    output wr_ready, wr_err,
    output rd_data, rd_data_valid
  );

endinterface

// File: rtl/efi_cfg_commit_fsm.sv
// efi_cfg_commit_fsm: IDLE/ARMED/APPLY commit sequencer, commit
// counter and write-ready gating. Ports: clk, reset_n, req/trig/sync in.
module efi_cfg_commit_fsm
  import efi_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       commit_req,
  input  logic       trigger,
  input  logic       synced,
  output logic       wr_ready,
  output logic       apply,
  output logic       commit_pending,
  output logic [7:0] commit_count
);

  commit_st_e st_q;
  commit_st_e st_d;
  logic       run_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q         <= CM_IDLE;
      run_q        <= 1'b0;
      commit_count <= 8'd0;
    end else begin
      st_q  <= st_d;
      run_q <= 1'b1;
      if (st_q == CM_APPLY)
        commit_count <= commit_count + 8'd1;
    end
  end

  // A stopped engine (!synced) has no tooth to wait for.
  always_comb begin
    st_d  = st_q;
    apply = 1'b0;
    unique case (st_q)
      CM_IDLE: begin
        if (commit_req)
          st_d = (trigger && synced) ? CM_APPLY
                                     : CM_ARMED;
      end
      CM_ARMED: begin
        if ((trigger && synced) || !synced)
          st_d = CM_APPLY;
      end
      CM_APPLY: begin
        apply = 1'b1;
        st_d  = commit_req ? CM_ARMED : CM_IDLE;
      end
      default: st_d = CM_IDLE;
    endcase
  end

  assign commit_pending = (st_q != CM_IDLE);
  assign wr_ready       = run_q && !apply;

endmodule

// File: rtl/efi_cfg_bank.sv
// efi_cfg_bank: shadow/active config register bank with atomic commit
// and RO status slots. Ports: clk, reset_n, bus (slave), status, commit.
module efi_cfg_bank
  import efi_cfg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0,
  parameter logic [NUM_REGS-1:0]        RO_MASK    = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  efi_cfg_bank_if.slave              bus,
  input  logic [NUM_REGS*DATA_W-1:0] status_in,
  input  logic                       commit_req,
  input  logic                       trigger,
  input  logic                       synced,
  output logic [NUM_REGS*DATA_W-1:0] cfg_active,
  output logic                       commit_pending,
  output logic [7:0]                 commit_count
);

  localparam int IDX_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NREG =
    (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] shd_q [NUM_REGS];
  logic [DATA_W-1:0] act_q [NUM_REGS];
  logic [DATA_W-1:0] sts   [NUM_REGS];

  logic              wr_ready;
  logic              apply;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              wr_in;
  logic              rd_in;
  logic              wr_acc;
  logic              wr_bad;
  logic [DATA_W-1:0] rd_val;

  efi_cfg_commit_fsm u_fsm (
    .clk            (clk),
    .reset_n        (reset_n),
    .commit_req     (commit_req),
    .trigger        (trigger),
    .synced         (synced),
    .wr_ready       (wr_ready),
    .apply          (apply),
    .commit_pending (commit_pending),
    .commit_count   (commit_count)
  );

  assign bus.wr_ready = wr_ready;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    assign sts[i] = status_in[i*DATA_W +: DATA_W];
    assign cfg_active[i*DATA_W +: DATA_W] = act_q[i];
  end

  assign wr_idx = bus.wr_addr[IDX_W-1:0];
  assign rd_idx = bus.rd_addr[IDX_W-1:0];
  assign wr_in  = {1'b0, bus.wr_addr} < NREG;
  assign rd_in  = {1'b0, bus.rd_addr} < NREG;
  assign wr_acc = bus.wr_valid && wr_ready;
  assign wr_bad = !wr_in || RO_MASK[wr_idx];

  // Dropped writes are still consumed; they only flag wr_err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        shd_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      bus.wr_err <= 1'b0;
    end else begin
      bus.wr_err <= wr_acc && wr_bad;
      if (wr_acc && !wr_bad)
        shd_q[wr_idx] <= bus.wr_data;
    end
  end

  // RO slots track status_in; the rest only move on apply.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        act_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i])
          act_q[i] <= sts[i];
        else if (apply)
          act_q[i] <= shd_q[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_in) begin
      if (RO_MASK[rd_idx])
        rd_val = sts[rd_idx];
      else if (bus.rd_bank)
        rd_val = act_q[rd_idx];
      else
        rd_val = shd_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rd_data       <= '0;
      bus.rd_data_valid <= 1'b0;
    end else begin
      bus.rd_data_valid <= bus.rd_en;
      if (bus.rd_en)
        bus.rd_data <= rd_val;
    end
  end

endmodule

// File: tb/tb_efi_cfg_bank.sv
// tb_efi_cfg_bank: random + directed stimulus against a cycle-level
// reference model; read responses go through a scoreboard queue.
module tb_efi_cfg_bank;
  import efi_cfg_pkg::*;

  localparam int NR = 16;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam logic [NR*DW-1:0] RV = DEF_RESET_VALS;
  localparam logic [NR-1:0]    RO = DEF_RO_MASK;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR*DW-1:0] status_in;
  logic             commit_req;
  logic             trigger;
  logic             synced;
  logic [NR*DW-1:0] cfg_active;
  logic             commit_pending;
  logic [7:0]       commit_count;

  efi_cfg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  efi_cfg_bank #(
    .NUM_REGS   (NR),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .RESET_VALS (RV),
    .RO_MASK    (RO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .status_in      (status_in),
    .commit_req     (commit_req),
    .trigger        (trigger),
    .synced         (synced),
    .cfg_active     (cfg_active),
    .commit_pending (commit_pending),
    .commit_count   (commit_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot(
    input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Reference model: registers as plain arrays, commit as
  // "armed"/"applying" flags following the commit rules.
  logic [DW-1:0] m_shd [NR];
  logic [DW-1:0] m_act [NR];
  bit            m_run, m_armed, m_apply;
  bit            m_err, m_rdv;
  logic [7:0]    m_cnt;
  logic [DW-1:0] m_rdd;
  logic [DW-1:0] rdq [$];

  always @(posedge clk) begin : mdl
    int ra;
    int wa;
    bit acc;
    logic [DW-1:0] rv;
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) begin
        m_shd[i] = RV[i*DW +: DW];
        m_act[i] = RV[i*DW +: DW];
      end
      m_run = 0; m_armed = 0; m_apply = 0;
      m_err = 0; m_rdv = 0;
      m_cnt = 8'd0; m_rdd = '0;
      rdq.delete();
    end else begin
      m_rdv = bus.rd_en;
      if (bus.rd_en) begin
        ra = int'(bus.rd_addr);
        if (ra >= NR) rv = '0;
        else if (RO[ra]) rv = slot(status_in, ra);
        else if (bus.rd_bank) rv = m_act[ra];
        else rv = m_shd[ra];
        m_rdd = rv;
        rdq.push_back(rv);
      end
      acc = bus.wr_valid && m_run && !m_apply;
      wa  = int'(bus.wr_addr);
      if (m_apply) begin
        for (int i = 0; i < NR; i++)
          if (!RO[i]) m_act[i] = m_shd[i];
        m_cnt   = m_cnt + 8'd1;
        m_apply = 0;
        m_armed = commit_req;
      end else if (m_armed) begin
        if (!synced || trigger) begin
          m_armed = 0; m_apply = 1;
        end
      end else if (commit_req) begin
        if (synced && trigger) m_apply = 1;
        else m_armed = 1;
      end
      for (int i = 0; i < NR; i++)
        if (RO[i]) m_act[i] = slot(status_in, i);
      m_err = 0;
      if (acc) begin
        if (wa >= NR) m_err = 1;
        else if (RO[wa]) m_err = 1;
        else m_shd[wa] = bus.wr_data;
      end
      m_run = 1;
    end
  end

  logic [NR*DW-1:0] exp_cfg;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NR; i++)
        exp_cfg[i*DW +: DW] = m_act[i];
      chk("cfg_active", cfg_active, exp_cfg);
      chk("commit_count", commit_count, m_cnt);
      chk("commit_pending", commit_pending,
          m_armed || m_apply);
      chk("wr_ready", bus.wr_ready,
          m_run && !m_apply);
      chk("wr_err", bus.wr_err, m_err);
      chk("rd_data_valid", bus.rd_data_valid, m_rdv);
      if (bus.rd_data_valid) begin
        if (rdq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rd_sb: unexpected response %0h",
                   bus.rd_data);
        end else begin
          chk("rd_data", bus.rd_data, rdq.pop_front());
        end
      end else begin
        chk("rd_hold", bus.rd_data, m_rdd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a,
                          input logic [DW-1:0] d);
    bit r;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(a);
    bus.wr_data  = d;
    for (int k = 0; k < 8; k++) begin
      r = m_run && !m_apply;
      cyc();
      if (r) break;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input int a, input bit b);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    bus.rd_bank = b;
    cyc();
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_req();
    commit_req = 1'b1;
    cyc();
    commit_req = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    status_in    = '0;
    commit_req   = 1'b0;
    trigger      = 1'b0;
    synced       = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.rd_bank  = 1'b0;
    cyc();
    chk_on = 1'b1;
    repeat (2) cyc();
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    reset_n = 1'b1;
    cyc();
    chk("rst_slot1", slot(cfg_active, 1), 60);
    chk("rst_slot5", slot(cfg_active, 5), 7680);
    chk("rst_slot11", slot(cfg_active, 11), 342);
    chk("rst_count", commit_count, 0);
    chk("rel_wr_ready", bus.wr_ready, 1'b1);

    // triggered commit
    synced = 1'b1;
    do_write(REG_INJ_A_ANG, 16'd400);
    do_read(REG_INJ_A_ANG, 1'b0);
    do_read(REG_INJ_A_ANG, 1'b1);
    pulse_req();
    repeat (4) cyc();
    chk("armed_slot10", slot(cfg_active, 10), 342);
    chk("armed_pend", commit_pending, 1'b1);
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    cyc();
    chk("trig_slot10", slot(cfg_active, 10), 400);
    chk("trig_count", commit_count, 1);

    // stopped engine commits without trigger
    synced = 1'b0;
    do_write(REG_INJ_A_PW, 16'd3000);
    pulse_req();
    repeat (2) cyc();
    chk("stop_slot12", slot(cfg_active, 12), 3000);

    // RO and out-of-range accesses
    do_write(REG_STATUS, 16'd5);
    status_in[REG_STATUS*DW +: DW] = 16'd1;
    do_read(REG_STATUS, 1'b0);
    do_write(20, 16'd7);
    do_read(25, 1'b1);

    // write stalled by APPLY
    synced     = 1'b1;
    commit_req = 1'b1;
    trigger    = 1'b1;
    cyc();
    commit_req = 1'b0;
    trigger    = 1'b0;
    do_write(REG_MISSING, 16'd9);
    chk("stall_slot3", slot(cfg_active, 3), 2);
    do_read(REG_MISSING, 1'b0);
    synced = 1'b0;
    pulse_req();
    repeat (2) cyc();
    chk("stall_commit", slot(cfg_active, 3), 9);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = AW'($urandom_range(0, 18));
      bus.wr_data  = DW'($urandom);
      bus.rd_en    = ($urandom_range(0, 1) == 0);
      bus.rd_addr  = AW'($urandom_range(0, 18));
      bus.rd_bank  = 1'($urandom_range(0, 1));
      commit_req   = ($urandom_range(0, 9) == 0);
      trigger      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) synced = ~synced;
      status_in[14*DW +: DW] = DW'($urandom);
      status_in[15*DW +: DW] = DW'($urandom);
      cyc();
    end
    bus.wr_valid = 1'b0;
    bus.rd_en    = 1'b0;
    commit_req   = 1'b0;
    trigger      = 1'b0;
    synced       = 1'b0;
    repeat (4) cyc();

    // reset while armed
    synced = 1'b1;
    pulse_req();
    cyc();
    chk("pre_rst_pend", commit_pending, 1'b1);
    reset_n = 1'b0;
    repeat (2) cyc();
    chk("rst_arm_pend", commit_pending, 1'b0);
    chk("rst_arm_count", commit_count, 0);
    chk("rst_arm_slot10", slot(cfg_active, 10), 342);
    chk("rst_arm_slot12", slot(cfg_active, 12), 2000);
    reset_n = 1'b1;
    cyc();

    // counter wrap
    synced = 1'b0;
    for (int k = 0; k < 256; k++) begin
      pulse_req();
      repeat (2) cyc();
      if (k == 254)
        chk("count_255", commit_count, 255);
    end
    chk("count_wrap", commit_count, 0);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
